// File: rtl/ram_dump_pkg.sv
// Shared definitions for the RAM readback (dump) path.
// Holds the FSM state encoding and the byte-lane constants that the
// download packer also uses, so packing and unpacking stay exact inverses.
package ram_dump_pkg;

  // FSM states; ST_SUM is only reachable when RAM_DUMP_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_SUM,
    ST_DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  // Byte lane of the last byte in a word (little-endian: lane 0 = bits 7:0).
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  // Select one little-endian byte lane out of a 32-bit word.
  function automatic logic [BYTE_W-1:0] byte_lane(input logic [31:0]       word,
                                                   input logic [LANE_W-1:0] lane);
    return word[BYTE_W*lane +: BYTE_W];
  endfunction

endpackage : ram_dump_pkg

// File: rtl/ram_dump_if.sv
// Bus bundle between the dump engine, the RAM read port and the UART TX.
// master = dump engine side, slave = RAM/UART side.
interface ram_dump_if;

  logic [31:0] rd_addr;     // word index to RAM read port
  logic [31:0] rd_data;     // RAM read data, combinational from rd_addr
  logic        o_tx_valid;  // byte available for UART TX
  logic [7:0]  o_tx_data;   // byte to transmit
  logic        i_tx_ready;  // UART TX accepts byte this cycle

  modport master (
    output rd_addr,
    output o_tx_valid,
    output o_tx_data,
    input  rd_data,
    input  i_tx_ready
  );

  modport slave (
    input  rd_addr,
    input  o_tx_valid,
    input  o_tx_data,
    output rd_data,
    output i_tx_ready
  );

endinterface : ram_dump_if

// File: rtl/ram_dump.sv
// RAM readback engine: on i_start it reads i_count words starting at word
// index i_base and streams them to the UART TX as little-endian bytes.
// Optional trailing checksum byte: define RAM_DUMP_CHECKSUM_EN.
module ram_dump
  import ram_dump_pkg::*;
#(
  parameter int LOGD = 10
) (
  input  logic            clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [31:0]     i_base,
  input  logic [LOGD:0]   i_count,
  ram_dump_if.master      bus,
  output logic            o_busy,
  output logic            o_done
);

  state_t              r_state;
  logic [31:0]         r_addr;
  logic [LOGD:0]       r_remaining;
  logic [31:0]         r_word;
  logic [LANE_W-1:0]   r_idx;
  logic                r_tx_valid;
  logic [7:0]          r_tx_data;
  logic                r_busy;
  logic                r_done;
`ifdef RAM_DUMP_CHECKSUM_EN
  logic [7:0]          r_sum;
  logic [7:0]          w_sum_next;
`endif

  logic [LANE_W-1:0]   w_next_idx;
  logic [7:0]          w_next_byte;
  logic                w_last_word;

  // Byte mux: next lane of the held word, and last-word detection.
  assign w_next_idx  = r_idx + LANE_W'(1);
  assign w_next_byte = byte_lane(r_word, w_next_idx);
  assign w_last_word = (r_remaining == (LOGD+1)'(1));
`ifdef RAM_DUMP_CHECKSUM_EN
  assign w_sum_next  = r_sum + r_tx_data;
`endif

  assign bus.rd_addr    = r_addr;
  assign bus.o_tx_valid = r_tx_valid;
  assign bus.o_tx_data  = r_tx_data;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

  // Dump FSM with registered outputs; synchronous reset aborts any dump.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every branch sees the pre-edge values.
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_word      <= '0;
      r_idx       <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef RAM_DUMP_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      // NOTE: o_done defaults low here so it can only be a one-cycle pulse.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_addr      <= i_base;
            r_remaining <= i_count;
            r_busy      <= 1'b1;
`ifdef RAM_DUMP_CHECKSUM_EN
            r_sum       <= '0;
`endif
            if (i_count == '0) begin
`ifdef RAM_DUMP_CHECKSUM_EN
              // Empty dump still sends its (zero) checksum byte.
              r_state    <= ST_SUM;
              r_tx_valid <= 1'b1;
              r_tx_data  <= 8'h00;
`else
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
`endif
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end

        ST_FETCH: begin
          // RAM data is combinational from rd_addr (= r_addr); capture it whole.
          r_word     <= bus.rd_data;
          r_idx      <= '0;
          r_tx_valid <= 1'b1;
          r_tx_data  <= byte_lane(bus.rd_data, '0);
          r_state    <= ST_SEND;
        end

        ST_SEND: begin
          if (bus.i_tx_ready) begin
`ifdef RAM_DUMP_CHECKSUM_EN
            r_sum <= w_sum_next;
`endif
            if (r_idx != LAST_LANE) begin
              r_idx     <= w_next_idx;
              r_tx_data <= w_next_byte;
            end else begin
              r_addr      <= r_addr + 32'd1;
              r_remaining <= r_remaining - (LOGD+1)'(1);
              if (w_last_word) begin
`ifdef RAM_DUMP_CHECKSUM_EN
                // Valid stays high; the checksum byte replaces the data byte.
                r_state   <= ST_SUM;
                r_tx_data <= w_sum_next;
`else
                r_tx_valid <= 1'b0;
                r_state    <= ST_DONE;
                r_done     <= 1'b1;
`endif
              end else begin
                r_tx_valid <= 1'b0;
                r_state    <= ST_FETCH;
              end
            end
          end
        end

`ifdef RAM_DUMP_CHECKSUM_EN
        ST_SUM: begin
          if (bus.i_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
          end
        end
`endif

        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : ram_dump

// File: tb/tb_ram_dump.sv
// Self-checking bench for ram_dump. A byte-queue model derived from the RAM
// contents predicts every transferred byte; a negedge compare process checks
// each transfer, the valid/data hold rule and the done pulse.
module tb_ram_dump;

  localparam int LOGD  = 10;
  localparam int DEPTH = 1 << LOGD;

`ifdef RAM_DUMP_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [31:0]   i_base;
  logic [LOGD:0] i_count;
  logic          o_busy;
  logic          o_done;

  ram_dump_if bus ();

  logic [31:0] ram [DEPTH];
  assign bus.rd_data = ram[bus.rd_addr[LOGD-1:0]];

  ram_dump #(.LOGD(LOGD)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_base  (i_base),
    .i_count (i_count),
    .bus     (bus),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // TX ready driver: always-ready or 1-in-3 backpressure.
  int ready_mode = 0;
  int cyc = 0;
  initial bus.i_tx_ready = 1'b1;
  always @(posedge clk) begin
    cyc++;
    #1;
    bus.i_tx_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  // Behavioural model: the expected byte stream of a dump.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic model_dump(input logic [31:0] base, input int count);
    logic [7:0]  sum;
    logic [31:0] word;
    int          idx;
    sum = 8'h00;
    for (int w = 0; w < count; w++) begin
      idx  = (int'(base[LOGD-1:0]) + w) % DEPTH;
      word = ram[idx];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(8'(word >> (8 * b)));
        sum = sum + 8'(word >> (8 * b));
      end
    end
    if (EXTRA == 1) exp_q.push_back(sum);
  endtask

  // Compare process: every transfer, hold rule and done pulse.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_done = 1'b0;
  always @(negedge clk) begin
    if (i_reset) begin
      prev_hold = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", bus.o_tx_valid, 1'b1);
        check("hold_data", bus.o_tx_data, prev_data);
      end
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        check("byte_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("tx_byte", bus.o_tx_data, exp_q.pop_front());
        got_q.push_back(bus.o_tx_data);
      end
      if (o_done) begin
        check("done_after_last_byte", exp_q.size(), 0);
        check("done_single_cycle", prev_done, 1'b0);
      end
      prev_hold = bus.o_tx_valid && !bus.i_tx_ready;
      prev_data = bus.o_tx_data;
      prev_done = o_done;
    end
  end

  logic [31:0] addr_log [64];

  task automatic do_start(input logic [31:0] base, input int count);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_base  = base;
    i_count = count[LOGD:0];
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  // Runs one dump; cycle index 0 is the FETCH cycle right after start is taken.
  task automatic run_dump(input logic [31:0] base, input int count, input int budget,
                          input int pulse_at, output int first_v, output int done_idx);
    got_q.delete();
    model_dump(base, count);
    do_start(base, count);
    first_v  = -1;
    done_idx = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (k < 64) addr_log[k] = bus.rd_addr;
      if (k == 0) check("busy_during_dump", o_busy, 1'b1);
      if (bus.o_tx_valid && first_v < 0) first_v = k;
      if (k == pulse_at) begin
        i_start = 1'b1;
        i_base  = 32'd0;
        i_count = (LOGD+1)'(5);
      end else begin
        i_start = 1'b0;
      end
      if (o_done) begin
        done_idx = k;
        break;
      end
    end
    i_start = 1'b0;
    check("done_within_budget", done_idx >= 0, 1'b1);
    @(negedge clk);
    check("idle_after_done", o_busy, 1'b0);
    check("all_bytes_sent", exp_q.size(), 0);
    check("byte_total", got_q.size(), 4 * count + EXTRA);
  endtask

  // Compare the first 8 received bytes against a hand-packed little-endian value.
  task automatic check_bytes(input string name, input logic [63:0] exp_bytes);
    for (int i = 0; i < 8; i++) begin
      check(name, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_bytes[8*i +: 8]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv;
    int di;
    int seen;
    logic [9:0] a;

    i_reset = 1'b1;
    i_start = 1'b0;
    i_base  = '0;
    i_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      a = 10'(i);
      ram[i] = {a[7:0] ^ 8'hA5, a[7:0], ~a[7:0], a[7:0] + 8'h3C};
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_valid", bus.o_tx_valid, 1'b0);
    check("reset_tx_data", bus.o_tx_data, 8'h00);
    check("reset_rd_addr", bus.rd_addr, 32'h0);
    check("reset_busy", o_busy, 1'b0);
    check("reset_done", o_done, 1'b0);
    @(posedge clk);
    #1;
    i_reset = 1'b0;

    // Basic dump, TX always ready.
    ram[4] = 32'h4433_2211;
    ram[5] = 32'h8877_6655;
    run_dump(32'd4, 2, 200, -1, fv, di);
    check("basic_first_valid", fv, 1);
    check("basic_done_cycle", di, 10 + EXTRA);
    check_bytes("basic_bytes", 64'h8877_6655_4433_2211);

    // Same dump under backpressure.
    ready_mode = 1;
    run_dump(32'd4, 2, 200, -1, fv, di);
    check_bytes("bp_bytes", 64'h8877_6655_4433_2211);
    ready_mode = 0;

    // Zero count.
    run_dump(32'd0, 0, 20, -1, fv, di);
    if (EXTRA == 1) begin
      check("zero_first_valid", fv, 0);
      check("zero_done_cycle", di, 1);
      check("zero_checksum", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h00);
    end else begin
      check("zero_no_valid", fv, -1);
      check("zero_done_cycle", di, 0);
    end

    // Wrap within the RAM depth.
    ram[1023] = 32'hDEAD_BEEF;
    ram[0]    = 32'h0BAD_F00D;
    run_dump(32'd1023, 2, 200, -1, fv, di);
    check("wrap_addr0", addr_log[0], 32'd1023);
    check("wrap_addr1", addr_log[5], 32'd1024);
    check_bytes("wrap_bytes", 64'h0BAD_F00D_DEAD_BEEF);

    // Wrap of the 32-bit word index.
    run_dump(32'hFFFF_FFFF, 2, 200, -1, fv, di);
    check("wrap32_addr0", addr_log[0], 32'hFFFF_FFFF);
    check("wrap32_addr1", addr_log[5], 32'h0);
    check_bytes("wrap32_bytes", 64'h0BAD_F00D_DEAD_BEEF);

    // Start pulse while busy is ignored.
    run_dump(32'd4, 2, 200, 3, fv, di);
    check("busy_start_done_cycle", di, 10 + EXTRA);
    check_bytes("busy_start_bytes", 64'h8877_6655_4433_2211);
    repeat (10) @(negedge clk);
    check("busy_start_not_queued", o_busy, 1'b0);

    // Reset after three bytes: abort with no done pulse.
    got_q.delete();
    model_dump(32'd4, 2);
    do_start(32'd4, 2);
    repeat (4) @(posedge clk);
    #1;
    check("bytes_before_reset", got_q.size(), 3);
    i_reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("reset_abort_valid", bus.o_tx_valid, 1'b0);
    check("reset_abort_busy", o_busy, 1'b0);
    check("reset_abort_done", o_done, 1'b0);
    i_reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (o_done || bus.o_tx_valid) seen++;
    end
    check("reset_abort_quiet", seen, 0);

    // Full-memory dump (top bit of i_count set).
    run_dump(32'd4, DEPTH, 6000, -1, fv, di);
    check("full_done_cycle", di, 5 * DEPTH + EXTRA);

`ifdef RAM_DUMP_CHECKSUM_EN
    // Checksum wraps modulo 256.
    ram[8] = 32'h0101_0101;
    ram[9] = 32'h0000_00FF;
    run_dump(32'd8, 2, 200, -1, fv, di);
    check_bytes("sum_bytes", 64'h0000_00FF_0101_0101);
    check("sum_value", got_q.size() > 8 ? got_q[8] : 8'hxx, 8'h03);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ram_dump
